// File: rtl/core_types_pkg.sv
// ---------------------------------------------------------------------------
// core_types_pkg
// Shared rename-stage types and sizing.
//   phys_reg_tag_t      : physical register tag
//   checkpoint_column_t : checkpoint slot index
//   free_list_ptr_t     : free-list pointer = {wrap bit, index}
// FREE_LIST_DEPTH must be a power of two so that the pointer
// arithmetic wraps naturally.
// ---------------------------------------------------------------------------
package core_types_pkg;

    localparam int NUM_ARCH_REGS      = 32;
    localparam int NUM_PHYS_REGS      = 64;
    localparam int CHECKPOINT_COLUMNS = 4;

    localparam int PHYS_TAG_W      = $clog2(NUM_PHYS_REGS);
    localparam int FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int FL_IDX_W        = $clog2(FREE_LIST_DEPTH);
    localparam int FL_CNT_W        = FL_IDX_W + 1;

    localparam logic [FL_CNT_W-1:0] FL_DEPTH_CNT = FL_CNT_W'(FREE_LIST_DEPTH);

    typedef logic [PHYS_TAG_W-1:0]                 phys_reg_tag_t;
    typedef logic [$clog2(CHECKPOINT_COLUMNS)-1:0] checkpoint_column_t;

    typedef struct packed {
        logic                wrap;
        logic [FL_IDX_W-1:0] idx;
    } free_list_ptr_t;

    // Step a pointer by +1 (dec=0) or -1 (dec=1). Treating {wrap,idx} as a
    // single counter makes the wrap bit toggle exactly when idx wraps.
    function automatic free_list_ptr_t fl_ptr_step(input free_list_ptr_t p,
                                                   input logic dec);
        logic [FL_CNT_W-1:0] v;
        v = p;
        v = dec ? (v - 1'b1) : (v + 1'b1);
        return free_list_ptr_t'(v);
    endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list
// Circular FIFO of free physical register tags for rename.
//   Dispatch pops the head tag (dequeue), commit pushes back freed tags
//   (enqueue), branch recovery un-pops speculated tags one per cycle
//   (revert). With FREE_LIST_CHECKPOINT_EN defined, the head pointer can be
//   saved into a slot and restored in a single cycle.
//
// Ports
//   CLK, nRST                 clock, asynchronous active-low reset
//   DUT_error                 registered protocol-violation flag (one cycle)
//   dequeue_valid             rename consumes the head tag
//   dequeue_phys_reg_tag      current head tag (combinational)
//   free_list_empty/full      occupancy flags
//   free_count                number of free entries
//   enqueue_valid/_tag        commit returns a tag
//   revert_valid/_tag         undo youngest dequeue; tag is only checked
//   save_checkpoint_*         (FREE_LIST_CHECKPOINT_EN) save head into slot
//   restore_checkpoint_*      (FREE_LIST_CHECKPOINT_EN) rewind head to slot
// ---------------------------------------------------------------------------
module phys_reg_free_list
    import core_types_pkg::*;
(
    input  logic                    CLK,
    input  logic                    nRST,
    output logic                    DUT_error,

    input  logic                    dequeue_valid,
    output phys_reg_tag_t           dequeue_phys_reg_tag,
    output logic                    free_list_empty,
    output logic                    free_list_full,
    output logic [FL_CNT_W-1:0]     free_count,

    input  logic                    enqueue_valid,
    input  phys_reg_tag_t           enqueue_phys_reg_tag,

    input  logic                    revert_valid,
    input  phys_reg_tag_t           revert_phys_reg_tag
`ifdef FREE_LIST_CHECKPOINT_EN
    ,
    input  logic                    save_checkpoint_valid,
    input  checkpoint_column_t      save_checkpoint_column,
    input  logic                    restore_checkpoint_valid,
    input  checkpoint_column_t      restore_checkpoint_column
`endif
);

    phys_reg_tag_t         array_q [FREE_LIST_DEPTH];
    free_list_ptr_t        head_q, head_d;
    free_list_ptr_t        tail_q, tail_d;
    logic                  DUT_error_q, DUT_error_d;

    free_list_ptr_t        head_m1, head_p1, tail_p1;
    logic [FL_CNT_W-1:0]   enq_next_count;
    logic                  enq_accept;
    logic                  empty, full;

    logic                  restore_hit;
    free_list_ptr_t        restore_head;

    assign head_m1 = fl_ptr_step(head_q, 1'b1);
    assign head_p1 = fl_ptr_step(head_q, 1'b0);
    assign tail_p1 = fl_ptr_step(tail_q, 1'b0);

    assign empty = (head_q == tail_q);
    assign full  = (head_q.idx == tail_q.idx) && (head_q.wrap != tail_q.wrap);

    assign dequeue_phys_reg_tag = array_q[head_q.idx];
    assign free_list_empty      = empty;
    assign free_list_full       = full;
    assign free_count           = tail_q - head_q;
    assign DUT_error            = DUT_error_q;

`ifdef FREE_LIST_CHECKPOINT_EN
    free_list_ptr_t ckpt_q [CHECKPOINT_COLUMNS];

    assign restore_hit  = restore_checkpoint_valid;
    assign restore_head = ckpt_q[restore_checkpoint_column];

    // Saved value is the post-update head so a same-cycle dequeue is
    // already accounted for in the checkpoint.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < CHECKPOINT_COLUMNS; i++) ckpt_q[i] <= '0;
        end else if (save_checkpoint_valid) begin
            ckpt_q[save_checkpoint_column] <= head_d;
        end
    end
`else
    assign restore_hit  = 1'b0;
    assign restore_head = '0;
`endif

    // Head update priority: restore > revert > dequeue. The enqueue
    // overflow check is done against the already-updated head so that a
    // same-cycle pop makes room and a same-cycle revert consumes room.
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        DUT_error_d    = 1'b0;
        enq_accept     = 1'b0;
        enq_next_count = '0;

        if (restore_hit) begin
            head_d = restore_head;
        end else if (revert_valid) begin
            if (full) begin
                DUT_error_d = 1'b1;
            end else begin
                head_d = head_m1;
                if (array_q[head_m1.idx] != revert_phys_reg_tag)
                    DUT_error_d = 1'b1;
            end
        end else if (dequeue_valid) begin
            if (empty) DUT_error_d = 1'b1;
            else       head_d = head_p1;
        end

        if (enqueue_valid) begin
            enq_next_count = tail_p1 - head_d;
            if ((enqueue_phys_reg_tag == '0) || (enq_next_count > FL_DEPTH_CNT)) begin
                DUT_error_d = 1'b1;
            end else begin
                enq_accept = 1'b1;
                tail_d     = tail_p1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q      <= '0;
            tail_q      <= '{wrap: 1'b1, idx: '0};
            DUT_error_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            DUT_error_q <= DUT_error_d;
        end
    end

    // At reset every non-architectural phys reg is free, in ascending order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < FREE_LIST_DEPTH; i++)
                array_q[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
        end else if (enq_accept) begin
            array_q[tail_q.idx] <= enqueue_phys_reg_tag;
        end
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
Circular FIFO of free physical register tags feeding rename. Dispatch pops the next free tag and sends it to the map table as the new dest mapping. Commit pushes back the old dest phys reg of retiring instrs. Revert un-pops speculated tags one at a time, mirroring map-table revert; optional checkpoint restore rewinds the head in one cycle.

Parameters:
NUM_ARCH_REGS, 32 (core_types_pkg), arch regs; phys 0..NUM_ARCH_REGS-1 mapped at reset
NUM_PHYS_REGS, 64 (core_types_pkg), total phys regs
FREE_LIST_DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS, max free entries
CHECKPOINT_COLUMNS, 4 (core_types_pkg), checkpoint slots (feature only)

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
DUT_error  out  1  registered protocol-violation flag
dequeue_valid  in  1  rename consumes head tag this cycle
dequeue_phys_reg_tag  out  phys_reg_tag_t  current head tag (combinational)
free_list_empty  out  1  no free tags
free_list_full  out  1  count == FREE_LIST_DEPTH
free_count  out  $clog2(FREE_LIST_DEPTH)+1  free entries
enqueue_valid  in  1  commit frees a tag
enqueue_phys_reg_tag  in  phys_reg_tag_t  freed tag
revert_valid  in  1  undo youngest dequeue
revert_phys_reg_tag  in  phys_reg_tag_t  speculated tag being returned (check only)
save_checkpoint_valid  in  1  (feature) save head pointer
save_checkpoint_column  in  checkpoint_column_t  (feature) slot = map table save_checkpoint_safe_column
restore_checkpoint_valid  in  1  (feature) rewind head
restore_checkpoint_column  in  checkpoint_column_t  (feature) slot to restore

Behaviour:
- State: array[FREE_LIST_DEPTH] of phys_reg_tag_t; head, tail pointers with extra wrap bit; count = tail-head (wrap-bit arithmetic); empty = (head==tail); full = index equal, wrap bits differ.
- Reset: array[i] = NUM_ARCH_REGS+i; head = 0; tail = {1,0} (full); DUT_error = 0; outputs empty=0, full=1, free_count=FREE_LIST_DEPTH, dequeue_phys_reg_tag = NUM_ARCH_REGS. Checkpoint head slots reset to 0. Reset mid-operation discards all state.
- dequeue_phys_reg_tag = array[head] always; valid only when ~empty.
- Dequeue: dequeue_valid & ~empty & ~revert_valid -> head+1 next cycle. dequeue_valid & empty -> no change, DUT_error next cycle. No enqueue->dequeue bypass: a tag enqueued in cycle N is first visible in N+1.
- Enqueue: write array[tail]=tag, tail+1. Independent of head ops. Enqueue of tag 0, or enqueue making next count > FREE_LIST_DEPTH -> dropped, DUT_error.
- Revert (priority over dequeue; dequeue ignored that cycle): head-1. If array[head-1] != revert_phys_reg_tag, or list full, DUT_error (head still moves unless full).
- Simultaneous enqueue+dequeue when full: both occur, count unchanged. Revert+enqueue: both occur, overflow rule above applies.
- Pointer wrap: index modulo FREE_LIST_DEPTH (power of 2), wrap bit toggles.
- DUT_error: next_DUT_error defaults to 0 each cycle; set by any violation; $display message on violation.

Optional Feature:
FREE_LIST_CHECKPOINT_EN: defined -> save ports present; save_checkpoint_valid stores current head (post-dequeue value if simultaneous) into slot. restore_checkpoint_valid sets head = slot value, highest priority, overrides revert/dequeue; enqueue still proceeds. Undefined -> save/restore ports and storage absent; recovery only through revert.

Decomposition:
- core_types_pkg: phys_reg_tag_t, checkpoint_column_t, NUM_PHYS_REGS, NUM_ARCH_REGS, CHECKPOINT_COLUMNS, new FREE_LIST_DEPTH and free_list_ptr_t (index + wrap bit).
- Single module; no sub-module needed.

Test Plan:
- Reset, 32 consecutive dequeues -> tags 32..63 in order, then empty=1, free_count=0; 33rd dequeue -> DUT_error=1 next cycle, head unchanged.
- From empty, enqueue 5, 9 -> next cycles dequeue returns 5 then 9; same-cycle enqueue+dequeue while empty -> dequeue errors, 5 visible next cycle.
- Dequeue 32, 33; revert tag 33 -> dequeue_phys_reg_tag = 33, free_count=31; revert tag 40 -> DUT_error.
- Full list, enqueue 7 -> dropped, DUT_error; enqueue 0 at any time -> DUT_error.
- Wrap: 40 interleaved dequeue/enqueue cycles -> FIFO order preserved across index wrap, free_count stays 32.
- FREE_LIST_CHECKPOINT_EN: save at head=2 into slot 1, dequeue 3 tags, restore slot 1 -> dequeue_phys_reg_tag = 34, free_count=30.
